// File: rtl/sgf_round_normalize.sv
`default_nettype none
// ============================================================================
//  Module      : sgf_round_normalize
//  Description : Normalizes the 2*SW-bit Karatsuba significand product to SW
//                bits, derives guard/sticky bits and applies IEEE-754
//                rounding (RNE, RTZ, RUP, RDN). It reports the exponent
//                increment and the inexact flag.
//                The datapath is a two-stage valid/ready pipeline. When the
//                output is stalled, the whole pipeline stalls.
//  Ports       : clk, rst       - clock and synchronous active-high reset
//                valid_i/ready_o - input handshake (ready_o = pipeline enable)
//                Data_S_i       - raw significand product, 2*SW bits
//                sign_i         - result sign, used by directed rounding
//                round_mode_i   - 00 RNE, 01 RTZ, 10 +inf, 11 -inf
//                valid_o/ready_i - output handshake
//                Sgf_o          - rounded significand, MSB is the hidden bit
//                exp_adj_o      - add 1 to the biased exponent
//                inexact_o      - guard or sticky bit was set
//  Revision    : 1.0 - initial release
// ============================================================================
module sgf_round_normalize #(
    parameter int SW = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2*SW-1:0] Data_S_i,
    input  logic            sign_i,
    input  logic [1:0]      round_mode_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [SW-1:0]   Sgf_o,
    output logic            exp_adj_o,
    output logic            inexact_o
);

    localparam logic [1:0] c_RM_RNE = 2'b00;
    localparam logic [1:0] c_RM_RTZ = 2'b01;
    localparam logic [1:0] c_RM_RUP = 2'b10;
    localparam logic [1:0] c_RM_RDN = 2'b11;

    // The pipeline advances whenever the output slot is empty or is being
    // drained this cycle. A stall freezes both stages. Bubbles are not
    // collapsed.
    logic w_en;
    assign w_en    = !valid_o || ready_i;
    assign ready_o = w_en;

    // ------------------------------------------------------------------
    // Stage 1: normalize. The product of two normalized significands lies
    // in [2^(2SW-2), 2^(2SW)), so only the top bit selects the alignment.
    // ------------------------------------------------------------------
    logic          w_top;
    logic [SW-1:0] w_sig;
    logic          w_g;
    logic          w_s;

    assign w_top = Data_S_i[2*SW-1];

    always_comb begin
        w_sig = Data_S_i[2*SW-2:SW-1];
        w_g   = Data_S_i[SW-2];
        w_s   = |Data_S_i[SW-3:0];
        if (w_top) begin
            w_sig = Data_S_i[2*SW-1:SW];
            w_g   = Data_S_i[SW-1];
            w_s   = |Data_S_i[SW-2:0];
        end
    end

    logic          r_s1_valid;
    logic [SW-1:0] r_s1_sig;
    logic          r_s1_g;
    logic          r_s1_s;
    logic          r_s1_ovf;
    logic          r_s1_sign;
    logic [1:0]    r_s1_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sig   <= '0;
            r_s1_g     <= 1'b0;
            r_s1_s     <= 1'b0;
            r_s1_ovf   <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_mode  <= c_RM_RNE;
        end else if (w_en) begin
            r_s1_valid <= valid_i;
            if (valid_i) begin
                r_s1_sig  <= w_sig;
                r_s1_g    <= w_g;
                r_s1_s    <= w_s;
                r_s1_ovf  <= w_top;
                r_s1_sign <= sign_i;
                r_s1_mode <= round_mode_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round. The increment is added one bit wider than the
    // significand, so a full-ones significand that rounds up shows as a
    // carry-out. That carry is renormalized to 1.000... with the exponent
    // bumped. An overflowed product (ovf) has sig <= 2^SW - 2, so it cannot
    // also carry out.
    // ------------------------------------------------------------------
    logic          w_inc;
    logic          w_gs;
    logic [SW:0]   w_sum;

    assign w_gs = r_s1_g | r_s1_s;

    always_comb begin
        w_inc = 1'b0;
        case (r_s1_mode)
            c_RM_RNE: w_inc = r_s1_g & (r_s1_s | r_s1_sig[0]);
            c_RM_RTZ: w_inc = 1'b0;
            c_RM_RUP: w_inc = !r_s1_sign & w_gs;
            c_RM_RDN: w_inc = r_s1_sign & w_gs;
            default:  w_inc = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, r_s1_sig} + {{SW{1'b0}}, w_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o   <= 1'b0;
            Sgf_o     <= '0;
            exp_adj_o <= 1'b0;
            inexact_o <= 1'b0;
        end else if (w_en) begin
            valid_o   <= r_s1_valid;
            inexact_o <= w_gs;
            if (w_sum[SW]) begin
                Sgf_o     <= {1'b1, {(SW-1){1'b0}}};
                exp_adj_o <= 1'b1;
            end else begin
                Sgf_o     <= w_sum[SW-1:0];
                exp_adj_o <= r_s1_ovf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sgf_round_normalize.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sgf_round_normalize
//  Description : Directed self-checking bench for sgf_round_normalize with
//                SW = 24. Expected values are hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sgf_round_normalize;

    localparam int SW = 24;

    logic            clk;
    logic            rst;
    logic            valid_i;
    logic            ready_o;
    logic [2*SW-1:0] Data_S_i;
    logic            sign_i;
    logic [1:0]      round_mode_i;
    logic            valid_o;
    logic            ready_i;
    logic [SW-1:0]   Sgf_o;
    logic            exp_adj_o;
    logic            inexact_o;

    int n_tests = 0;
    int n_fail  = 0;

    sgf_round_normalize #(.SW(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .Data_S_i     (Data_S_i),
        .sign_i       (sign_i),
        .round_mode_i (round_mode_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .Sgf_o        (Sgf_o),
        .exp_adj_o    (exp_adj_o),
        .inexact_o    (inexact_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] d;
        logic        s;
        logic [1:0]  m;
        logic [23:0] es;
        logic        ea;
        logic        ei;
    } vec_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one product, then confirm it appears exactly two edges later.
    task automatic run_one(input string tag, input logic [47:0] d, input logic s,
                           input logic [1:0] m, input logic [23:0] es,
                           input logic ea, input logic ei);
        Data_S_i     = d;
        sign_i       = s;
        round_mode_i = m;
        valid_i      = 1'b1;
        ready_i      = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        check({tag, " valid@1"}, {63'd0, valid_o}, 64'd0);
        @(posedge clk); #1;
        check({tag, " valid@2"}, {63'd0, valid_o}, 64'd1);
        check({tag, " sgf"},     {40'd0, Sgf_o},   {40'd0, es});
        check({tag, " adj"},     {63'd0, exp_adj_o}, {63'd0, ea});
        check({tag, " inexact"}, {63'd0, inexact_o}, {63'd0, ei});
    endtask

    vec_t        sv[4];
    int          in_idx;
    int          out_idx;
    bit          stalled_prev;
    logic [23:0] held_sgf;
    logic        held_adj;
    logic        held_inex;

    initial begin
        rst          = 1'b1;
        valid_i      = 1'b0;
        ready_i      = 1'b1;
        Data_S_i     = '0;
        sign_i       = 1'b0;
        round_mode_i = 2'b00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst valid_o", {63'd0, valid_o},   64'd0);
        check("rst sgf",     {40'd0, Sgf_o},     64'd0);
        check("rst adj",     {63'd0, exp_adj_o}, 64'd0);
        check("rst inexact", {63'd0, inexact_o}, 64'd0);
        check("rst ready_o", {63'd0, ready_o},   64'd1);
        rst = 1'b0;

        // Exact power of two, no overflow
        run_one("exact",      48'h400000000000, 1'b0, 2'b00, 24'h800000, 1'b0, 1'b0);
        // 0xFFFFFF squared: overflowed product, G=0, S=1
        run_one("sq rne",     48'hFFFFFE000001, 1'b0, 2'b00, 24'hFFFFFE, 1'b1, 1'b1);
        run_one("sq rup+",    48'hFFFFFE000001, 1'b0, 2'b10, 24'hFFFFFF, 1'b1, 1'b1);
        run_one("sq rdn+",    48'hFFFFFE000001, 1'b0, 2'b11, 24'hFFFFFE, 1'b1, 1'b1);
        run_one("sq rdn-",    48'hFFFFFE000001, 1'b1, 2'b11, 24'hFFFFFF, 1'b1, 1'b1);
        run_one("sq rup-",    48'hFFFFFE000001, 1'b1, 2'b10, 24'hFFFFFE, 1'b1, 1'b1);
        // Tie with odd LSB rounds up into carry-out
        run_one("carry rne",  48'h7FFFFFC00000, 1'b0, 2'b00, 24'h800000, 1'b1, 1'b1);
        run_one("carry rtz",  48'h7FFFFFC00000, 1'b0, 2'b01, 24'hFFFFFF, 1'b0, 1'b1);
        // Tie with even LSB stays put; above half rounds up
        run_one("tie even",   48'h400000400000, 1'b0, 2'b00, 24'h800000, 1'b0, 1'b1);
        run_one("above half", 48'h400000600000, 1'b0, 2'b00, 24'h800001, 1'b0, 1'b1);
        // Directed rounding on an exact value never increments
        run_one("exact rdn-", 48'h400000000000, 1'b1, 2'b11, 24'h800000, 1'b0, 1'b0);

        // Backpressure: four products streamed, ready_i low in cycles 3..5
        sv[0] = '{48'h400000000000, 1'b0, 2'b00, 24'h800000, 1'b0, 1'b0};
        sv[1] = '{48'hFFFFFE000001, 1'b0, 2'b10, 24'hFFFFFF, 1'b1, 1'b1};
        sv[2] = '{48'h7FFFFFC00000, 1'b0, 2'b00, 24'h800000, 1'b1, 1'b1};
        sv[3] = '{48'h400000600000, 1'b0, 2'b00, 24'h800001, 1'b0, 1'b1};
        in_idx       = 0;
        out_idx      = 0;
        stalled_prev = 1'b0;
        held_sgf     = '0;
        held_adj     = 1'b0;
        held_inex    = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 20; c++) begin
            ready_i = !(c >= 3 && c <= 5);
            if (in_idx < 4) begin
                Data_S_i     = sv[in_idx].d;
                sign_i       = sv[in_idx].s;
                round_mode_i = sv[in_idx].m;
                valid_i      = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            #1;
            if (c >= 3 && c <= 5) begin
                check($sformatf("stall valid_o c%0d", c), {63'd0, valid_o}, 64'd1);
                check($sformatf("stall ready_o c%0d", c), {63'd0, ready_o}, 64'd0);
            end
            if (stalled_prev) begin
                check($sformatf("hold sgf c%0d", c),     {40'd0, Sgf_o},     {40'd0, held_sgf});
                check($sformatf("hold adj c%0d", c),     {63'd0, exp_adj_o}, {63'd0, held_adj});
                check($sformatf("hold inexact c%0d", c), {63'd0, inexact_o}, {63'd0, held_inex});
            end
            if (valid_o && ready_i) begin
                if (out_idx < 4) begin
                    check($sformatf("stream sgf #%0d", out_idx), {40'd0, Sgf_o},     {40'd0, sv[out_idx].es});
                    check($sformatf("stream adj #%0d", out_idx), {63'd0, exp_adj_o}, {63'd0, sv[out_idx].ea});
                    check($sformatf("stream inx #%0d", out_idx), {63'd0, inexact_o}, {63'd0, sv[out_idx].ei});
                end
                out_idx++;
            end
            stalled_prev = valid_o && !ready_i;
            held_sgf     = Sgf_o;
            held_adj     = exp_adj_o;
            held_inex    = inexact_o;
            if (valid_i && ready_o) in_idx++;
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        check("stream accepted", 64'(in_idx), 64'd4);
        check("stream delivered", 64'(out_idx), 64'd4);

        // Reset with two items in flight and a new valid_i presented
        Data_S_i     = 48'hFFFFFE000001;
        sign_i       = 1'b0;
        round_mode_i = 2'b10;
        valid_i      = 1'b1;
        @(posedge clk); #1;
        Data_S_i = 48'h400000600000;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid rst valid_o", {63'd0, valid_o},   64'd0);
        check("mid rst sgf",     {40'd0, Sgf_o},     64'd0);
        check("mid rst adj",     {63'd0, exp_adj_o}, 64'd0);
        check("mid rst inexact", {63'd0, inexact_o}, 64'd0);
        rst     = 1'b0;
        valid_i = 1'b0;
        @(posedge clk); #1;
        check("post rst flushed", {63'd0, valid_o}, 64'd0);
        run_one("post rst", 48'h7FFFFFC00000, 1'b0, 2'b01, 24'hFFFFFF, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
